io_hub_mmio: RTL and testbench

Parametrised memory-mapped IO hub for the CPU top level. It replaces the fixed 16-switch / 8-digit IO block and generalises switch width and digit count. It adds a debounced confirm button with a sticky pending flag, an LED output register, and a hex/decimal display mode; decimal mode uses a sequential binary-to-BCD converter. It sits between the CPU's address/data bus and the board pins.

---
 rtl/io_hub_pkg.sv | 41 ++++
 rtl/bin2bcd_seq.sv | 84 ++++++++
 rtl/io_hub_mmio.sv | 204 ++++++++++++++++++++
 tb/tb_io_hub_mmio.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_hub_pkg.sv
// Shared constants for the memory-mapped IO hub.
// Contains the register offsets, the seven-segment patterns and the hex-to-segment decoder.
package io_hub_pkg;

   localparam logic [31:0] OFF_SW     = 32'h0000_0000;
   localparam logic [31:0] OFF_STATUS = 32'h0000_0004;
   localparam logic [31:0] OFF_DISP   = 32'h0000_0008;
   localparam logic [31:0] OFF_MODE   = 32'h0000_000C;
   localparam logic [31:0] OFF_LED    = 32'h0000_0010;

   localparam int unsigned BCD_DIGITS = 10;
   localparam int unsigned BCD_W      = 4 * BCD_DIGITS;

   localparam logic [7:0] SEG_BLANK = 8'h00;
   localparam logic [7:0] SEG_DASH  = 8'h40;

   // bit0..6 = a..g, bit7 = dp (never lit)
   function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
      logic [7:0] seg;
      case (nib)
         4'h0:    seg = 8'h3F;
         4'h1:    seg = 8'h06;
         4'h2:    seg = 8'h5B;
         4'h3:    seg = 8'h4F;
         4'h4:    seg = 8'h66;
         4'h5:    seg = 8'h6D;
         4'h6:    seg = 8'h7D;
         4'h7:    seg = 8'h07;
         4'h8:    seg = 8'h7F;
         4'h9:    seg = 8'h6F;
         4'hA:    seg = 8'h77;
         4'hB:    seg = 8'h7C;
         4'hC:    seg = 8'h39;
         4'hD:    seg = 8'h5E;
         4'hE:    seg = 8'h79;
         default: seg = 8'h71;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: 32 iterations per conversion, restartable at any time.
// bcd_o and ovf_o are valid in the cycle done_o pulses.
module bin2bcd_seq
   import io_hub_pkg::*;
#(
   parameter int unsigned DIGITS = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic [31:0]      bin_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [BCD_W-1:0] bcd_o,
   output logic             ovf_o
);

   typedef enum logic [0:0] {StIdle, StConv} state_e;

   localparam logic [BCD_W-1:0] LOW_MASK = (BCD_W'(1) << (4 * DIGITS)) - BCD_W'(1);

   state_e           state_q, state_d;
   logic [31:0]      bin_q, bin_d;
   logic [BCD_W-1:0] acc_q, acc_d;
   logic [BCD_W-1:0] adj, acc_shift;
   logic [4:0]       cnt_q, cnt_d;

   always_comb begin
      adj = acc_q;
      for (int i = 0; i < BCD_DIGITS; i++) begin
         if (acc_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
      acc_shift = {adj[BCD_W-2:0], bin_q[31]};
   end

   always_comb begin
      state_d = state_q;
      bin_d   = bin_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      done_o  = 1'b0;
      unique case (state_q)
         StIdle: ;
         StConv: begin
            bin_d = {bin_q[30:0], 1'b0};
            acc_d = acc_shift;
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
               state_d = StIdle;
               done_o  = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
      // A new start discards whatever was in flight, including a result about to complete
      if (start_i) begin
         state_d = StConv;
         bin_d   = bin_i;
         acc_d   = '0;
         cnt_d   = '0;
         done_o  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
         bin_q   <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         bin_q   <= bin_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
      end
   end

   assign busy_o = (state_q == StConv);
   assign bcd_o  = acc_shift;
   // Any nonzero BCD digit above the display width means the value is >= 10^DIGITS
   assign ovf_o  = |(acc_shift & ~LOW_MASK);

endmodule

// File: rtl/io_hub_mmio.sv
// Memory-mapped IO hub: switches, debounced confirm button, LEDs and a scanned
// two-bank seven-segment display with hex or decimal rendering.
module io_hub_mmio
   import io_hub_pkg::*;
#(
   parameter int unsigned SW_WIDTH        = 16,
   parameter int unsigned DIGITS          = 8,
   parameter int unsigned SCAN_DIV        = 100000,
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter logic [31:0] BASE_ADDR       = 32'hFFFF_FC00
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [31:0]         addr,
   input  logic                wr_en,
   input  logic                rd_en,
   input  logic [31:0]         wdata,
   output logic [31:0]         rdata,
   input  logic [SW_WIDTH-1:0] switch_in,
   input  logic                confirm_btn,
   output logic [SW_WIDTH-1:0] led_out,
   output logic [DIGITS-1:0]   tub_sel,
   output logic [7:0]          seg_left,
   output logic [7:0]          seg_right
);

   localparam int unsigned BANK      = DIGITS / 2;
   localparam logic [31:0] MODE_MASK = 32'h1 | (((32'd1 << DIGITS) - 32'd1) << 8);
   localparam logic [2:0]  LAST_K    = 3'(BANK - 1);
   localparam logic [2:0]  BANK_OFF  = 3'(BANK);

   logic                sel_sw, sel_status, sel_disp, sel_mode, sel_led;
   logic [SW_WIDTH-1:0] sw_meta_q, sw_sync_q, sw_q, sw_d;
   logic                btn_meta_q, btn_sync_q;
   logic                btn_stable_q, btn_stable_d, rise_q, rise_d;
   logic [31:0]         db_cnt_q, db_cnt_d;
   logic                pending_q, pending_d;
   logic [31:0]         disp_q, disp_d, mode_q, mode_d;
   logic [SW_WIDTH-1:0] led_q, led_d, led_out_q;
   logic [BCD_W-1:0]    bcd_q, bcd_d;
   logic                ovf_q, ovf_d;
   logic [31:0]         scan_cnt_q, scan_cnt_d;
   logic [2:0]          k_q, k_d, idx_l;
   logic [DIGITS-1:0]   tub_q, tub_d;
   logic [7:0]          seg_l_q, seg_l_d, seg_r_q, seg_r_d;
   logic                conv_start, conv_busy, conv_done, conv_ovf;
   logic [31:0]         conv_val;
   logic [BCD_W-1:0]    conv_bcd;

   assign sel_sw     = (addr == BASE_ADDR + OFF_SW);
   assign sel_status = (addr == BASE_ADDR + OFF_STATUS);
   assign sel_disp   = (addr == BASE_ADDR + OFF_DISP);
   assign sel_mode   = (addr == BASE_ADDR + OFF_MODE);
   assign sel_led    = (addr == BASE_ADDR + OFF_LED);

   // Converting a MODE write uses the DISP value already held
   assign conv_start = wr_en && (sel_disp || (sel_mode && wdata[0]));
   assign conv_val   = sel_disp ? wdata : disp_q;

   bin2bcd_seq #(
      .DIGITS(DIGITS)
   ) u_bin2bcd (
      .clk     (clk),
      .rst     (rst),
      .start_i (conv_start),
      .bin_i   (conv_val),
      .busy_o  (conv_busy),
      .done_o  (conv_done),
      .bcd_o   (conv_bcd),
      .ovf_o   (conv_ovf)
   );

   function automatic logic [7:0] digit_seg(input logic dec, input logic blank, input logic ovf,
                                            input logic [3:0] hex_nib, input logic [3:0] bcd_nib);
      logic [7:0] seg;
      if (blank)     seg = SEG_BLANK;
      else if (!dec) seg = hex_to_seg(hex_nib);
      else if (ovf)  seg = SEG_DASH;
      else           seg = hex_to_seg(bcd_nib);
      return seg;
   endfunction

   always_comb begin
      db_cnt_d     = db_cnt_q;
      btn_stable_d = btn_stable_q;
      rise_d       = 1'b0;
      if (btn_sync_q == btn_stable_q) begin
         db_cnt_d = '0;
      end else if (db_cnt_q == 32'(DEBOUNCE_CYCLES - 1)) begin
         db_cnt_d     = '0;
         btn_stable_d = btn_sync_q;
         rise_d       = btn_sync_q;
      end else begin
         db_cnt_d = db_cnt_q + 32'd1;
      end
   end

   always_comb begin
      disp_d    = disp_q;
      mode_d    = mode_q;
      led_d     = led_q;
      pending_d = pending_q;
      sw_d      = sw_q;
      bcd_d     = bcd_q;
      ovf_d     = ovf_q;
      if (wr_en) begin
         if (sel_disp) disp_d = wdata;
         if (sel_mode) mode_d = wdata & MODE_MASK;
         if (sel_led) led_d = wdata[SW_WIDTH-1:0];
         if (sel_status && wdata[0]) pending_d = 1'b0;
      end
      // A confirm edge overrides a simultaneous clear
      if (rise_q) begin
         pending_d = 1'b1;
         sw_d      = sw_sync_q;
      end
      if (conv_done) begin
         bcd_d = conv_bcd;
         ovf_d = conv_ovf;
      end
   end

   assign idx_l = k_q + BANK_OFF;

   always_comb begin
      scan_cnt_d = scan_cnt_q + 32'd1;
      k_d        = k_q;
      tub_d      = tub_q;
      seg_l_d    = seg_l_q;
      seg_r_d    = seg_r_q;
      if (scan_cnt_q == 32'(SCAN_DIV - 1)) begin
         scan_cnt_d = '0;
         k_d        = (k_q == LAST_K) ? 3'd0 : k_q + 3'd1;
         tub_d      = (DIGITS'(1) << k_q) | (DIGITS'(1) << idx_l);
         seg_r_d    = digit_seg(mode_q[0], mode_q[8 + k_q], ovf_q,
                                disp_q[4*k_q +: 4], bcd_q[4*k_q +: 4]);
         seg_l_d    = digit_seg(mode_q[0], mode_q[8 + idx_l], ovf_q,
                                disp_q[4*idx_l +: 4], bcd_q[4*idx_l +: 4]);
      end
   end

   always_comb begin
      rdata = '0;
      if (rd_en) begin
         if (sel_sw)     rdata = 32'(sw_q);
         if (sel_status) rdata = {30'd0, conv_busy, pending_q};
         if (sel_disp)   rdata = disp_q;
         if (sel_mode)   rdata = mode_q;
         if (sel_led)    rdata = 32'(led_q);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sw_meta_q    <= '0;
         sw_sync_q    <= '0;
         sw_q         <= '0;
         btn_meta_q   <= 1'b0;
         btn_sync_q   <= 1'b0;
         btn_stable_q <= 1'b0;
         rise_q       <= 1'b0;
         db_cnt_q     <= '0;
         pending_q    <= 1'b0;
         disp_q       <= '0;
         mode_q       <= '0;
         led_q        <= '0;
         led_out_q    <= '0;
         bcd_q        <= '0;
         ovf_q        <= 1'b0;
         scan_cnt_q   <= '0;
         k_q          <= '0;
         tub_q        <= '0;
         seg_l_q      <= '0;
         seg_r_q      <= '0;
      end else begin
         sw_meta_q    <= switch_in;
         sw_sync_q    <= sw_meta_q;
         sw_q         <= sw_d;
         btn_meta_q   <= confirm_btn;
         btn_sync_q   <= btn_meta_q;
         btn_stable_q <= btn_stable_d;
         rise_q       <= rise_d;
         db_cnt_q     <= db_cnt_d;
         pending_q    <= pending_d;
         disp_q       <= disp_d;
         mode_q       <= mode_d;
         led_q        <= led_d;
         led_out_q    <= led_q;
         bcd_q        <= bcd_d;
         ovf_q        <= ovf_d;
         scan_cnt_q   <= scan_cnt_d;
         k_q          <= k_d;
         tub_q        <= tub_d;
         seg_l_q      <= seg_l_d;
         seg_r_q      <= seg_r_d;
      end
   end

   assign led_out   = led_out_q;
   assign tub_sel   = tub_q;
   assign seg_left  = seg_l_q;
   assign seg_right = seg_r_q;

endmodule

// File: tb/tb_io_hub_mmio.sv
// Self-checking bench for io_hub_mmio using a scan-step scoreboard and a small reference model.
module tb_io_hub_mmio;

   localparam int unsigned SW_WIDTH = 16;
   localparam int unsigned DIGITS   = 8;
   localparam int unsigned SCAN_DIV = 8;
   localparam int unsigned DEBOUNCE = 20;
   localparam logic [31:0] BASE     = 32'hFFFF_FC00;
   localparam logic [31:0] R_SW     = 32'h00;
   localparam logic [31:0] R_STATUS = 32'h04;
   localparam logic [31:0] R_DISP   = 32'h08;
   localparam logic [31:0] R_MODE   = 32'h0C;
   localparam logic [31:0] R_LED    = 32'h10;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic [31:0]         addr = '0;
   logic                wr_en = 1'b0;
   logic                rd_en = 1'b0;
   logic [31:0]         wdata = '0;
   logic [31:0]         rdata;
   logic [SW_WIDTH-1:0] switch_in = '0;
   logic                confirm_btn = 1'b0;
   logic [SW_WIDTH-1:0] led_out;
   logic [DIGITS-1:0]   tub_sel;
   logic [7:0]          seg_left, seg_right;

   typedef struct packed {
      logic [7:0] tub;
      logic [7:0] left;
      logic [7:0] right;
   } scan_t;

   scan_t      sb_q[$];
   logic [7:0] exp_seg [DIGITS];
   int         n_chk = 0;
   int         n_err = 0;

   always #5 clk = ~clk;

   io_hub_mmio #(
      .SW_WIDTH        (SW_WIDTH),
      .DIGITS          (DIGITS),
      .SCAN_DIV        (SCAN_DIV),
      .DEBOUNCE_CYCLES (DEBOUNCE),
      .BASE_ADDR       (BASE)
   ) dut (
      .clk         (clk),
      .rst         (rst_n),
      .addr        (addr),
      .wr_en       (wr_en),
      .rd_en       (rd_en),
      .wdata       (wdata),
      .rdata       (rdata),
      .switch_in   (switch_in),
      .confirm_btn (confirm_btn),
      .led_out     (led_out),
      .tub_sel     (tub_sel),
      .seg_left    (seg_left),
      .seg_right   (seg_right)
   );

   function automatic logic [7:0] seg_of(input logic [3:0] n);
      logic [7:0] t [16];
      t = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
            8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
      return t[n];
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic bus_write(input logic [31:0] off, input logic [31:0] data);
      @(negedge clk);
      addr  = BASE + off;
      wdata = data;
      wr_en = 1'b1;
      @(posedge clk);
      #1;
      wr_en = 1'b0;
   endtask

   task automatic bus_read(input logic [31:0] off, output logic [31:0] data);
      addr  = BASE + off;
      rd_en = 1'b1;
      #1;
      data  = rdata;
      rd_en = 1'b0;
   endtask

   task automatic wait_step();
      logic [7:0] prev;
      int n;
      prev = tub_sel;
      n = 0;
      while (tub_sel == prev && n < 3 * SCAN_DIV) begin
         @(negedge clk);
         n++;
      end
      check_eq("scan_step", 32'(tub_sel != prev), 32'd1);
   endtask

   task automatic wait_conv();
      logic [31:0] st;
      int n;
      n = 0;
      bus_read(R_STATUS, st);
      while (st[1] && n < 200) begin
         @(posedge clk);
         #1;
         n++;
         bus_read(R_STATUS, st);
      end
      check_eq("conv_done", {31'd0, st[1]}, 32'd0);
   endtask

   // Align to the k=3 step, then score one full scan k=0..3 against exp_seg
   task automatic check_scan();
      scan_t e;
      wait_step();
      for (int i = 0; i < 4 && tub_sel != 8'h88; i++) wait_step();
      for (int k = 0; k < 4; k++) begin
         sb_q.push_back('{tub: 8'((1 << k) | (1 << (k + 4))),
                          left: exp_seg[k + 4], right: exp_seg[k]});
      end
      while (sb_q.size() > 0) begin
         wait_step();
         e = sb_q.pop_front();
         check_eq("scan_tub", 32'(tub_sel), 32'(e.tub));
         check_eq("scan_right", 32'(seg_right), 32'(e.right));
         check_eq("scan_left", 32'(seg_left), 32'(e.left));
      end
   endtask

   task automatic set_exp_hex(input logic [31:0] v);
      for (int i = 0; i < DIGITS; i++) exp_seg[i] = seg_of(v[4*i +: 4]);
   endtask

   task automatic set_exp_dec(input int unsigned v);
      int unsigned p;
      p = 1;
      for (int i = 0; i < DIGITS; i++) begin
         exp_seg[i] = seg_of(4'((v / p) % 10));
         p = p * 10;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not reach the summary");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] d;
      int n;

      // Reset state
      repeat (3) @(negedge clk);
      check_eq("rst_tub", 32'(tub_sel), 32'd0);
      check_eq("rst_led", 32'(led_out), 32'd0);
      rst_n = 1'b1;
      repeat (SCAN_DIV - 1) @(posedge clk);
      #1;
      check_eq("tub_before_first_step", 32'(tub_sel), 32'd0);
      @(posedge clk);
      #1;
      check_eq("first_tub", 32'(tub_sel), 32'h11);
      check_eq("first_right", 32'(seg_right), 32'h3F);
      check_eq("first_left", 32'(seg_left), 32'h3F);
      foreach (d[i]) d[i] = 1'b0;
      for (int r = 0; r < 5; r++) begin
         bus_read(32'(r * 4), d);
         check_eq("rst_reg", d, 32'd0);
      end

      // Hex display
      bus_write(R_DISP, 32'h1234_ABCD);
      set_exp_hex(32'h1234_ABCD);
      check_scan();

      // Decimal display; DISP write restarts the conversion started by MODE
      bus_write(R_MODE, 32'h1);
      bus_write(R_DISP, 32'd12345678);
      n = 0;
      bus_read(R_STATUS, d);
      while (d[1] && n < 100) begin
         n++;
         @(posedge clk);
         #1;
         bus_read(R_STATUS, d);
      end
      check_eq("busy_cycles", 32'(n), 32'd32);
      set_exp_dec(12345678);
      check_scan();

      // Overflow; the old BCD stays on display while converting
      bus_write(R_DISP, 32'd100000000);
      wait_step();
      bus_read(R_STATUS, d);
      check_eq("busy_mid", {31'd0, d[1]}, 32'd1);
      for (int k = 0; k < 4; k++) begin
         if (tub_sel[k]) begin
            check_eq("hold_right", 32'(seg_right), 32'(exp_seg[k]));
            check_eq("hold_left", 32'(seg_left), 32'(exp_seg[k + 4]));
         end
      end
      wait_conv();
      for (int i = 0; i < DIGITS; i++) exp_seg[i] = 8'h40;
      check_scan();

      // Blank mask on the left bank, hex mode
      bus_write(R_MODE, 32'h0000_F000);
      bus_read(R_MODE, d);
      check_eq("mode_rb", d, 32'h0000_F000);
      set_exp_hex(32'd100000000);
      for (int i = 4; i < 8; i++) exp_seg[i] = 8'h00;
      check_scan();

      // LED register
      bus_write(R_LED, 32'h0000_FFFF);
      @(posedge clk);
      #1;
      check_eq("led_out", 32'(led_out), 32'h0000_FFFF);
      bus_read(R_LED, d);
      check_eq("led_rb", d, 32'h0000_FFFF);

      // Bouncy press: only the final stable level registers
      switch_in = 16'hA5A5;
      repeat (5) @(posedge clk);
      #1;
      for (int b = 0; b < 3; b++) begin
         confirm_btn = 1'b1;
         repeat (5) @(posedge clk);
         #1;
         confirm_btn = 1'b0;
         repeat (4) @(posedge clk);
         #1;
      end
      bus_read(R_STATUS, d);
      check_eq("pending_after_bounce", {31'd0, d[0]}, 32'd0);
      confirm_btn = 1'b1;
      n = 0;
      d = '0;
      while (!d[0] && n < 100) begin
         @(posedge clk);
         #1;
         n++;
         bus_read(R_STATUS, d);
      end
      check_eq("press_latency", 32'(n), 32'(DEBOUNCE + 3));
      switch_in = 16'h1234;
      repeat (4) @(posedge clk);
      #1;
      bus_read(R_SW, d);
      check_eq("sw_latched", d, 32'h0000_A5A5);
      bus_write(R_SW, 32'h0);
      bus_read(R_SW, d);
      check_eq("sw_ro", d, 32'h0000_A5A5);
      bus_write(R_STATUS, 32'h1);
      bus_read(R_STATUS, d);
      check_eq("pending_clr", {31'd0, d[0]}, 32'd0);
      repeat (DEBOUNCE + 10) @(posedge clk);
      #1;
      bus_read(R_STATUS, d);
      check_eq("single_edge", {31'd0, d[0]}, 32'd0);
      confirm_btn = 1'b0;
      repeat (DEBOUNCE + 10) @(posedge clk);
      #1;
      bus_read(R_STATUS, d);
      check_eq("release_no_edge", {31'd0, d[0]}, 32'd0);

      // Read gating and unmapped addresses
      bus_read(32'h14, d);
      check_eq("unmapped_rd", d, 32'd0);
      addr  = BASE + R_DISP;
      rd_en = 1'b0;
      #1;
      check_eq("rd_en_low", rdata, 32'd0);

      // Reset during a conversion
      bus_write(R_MODE, 32'h1);
      repeat (5) @(posedge clk);
      #1;
      bus_read(R_STATUS, d);
      check_eq("busy_pre_rst", {31'd0, d[1]}, 32'd1);
      rst_n = 1'b0;
      #1;
      check_eq("arst_tub", 32'(tub_sel), 32'd0);
      check_eq("arst_segs", {16'd0, seg_left, seg_right}, 32'd0);
      check_eq("arst_led", 32'(led_out), 32'd0);
      bus_read(R_MODE, d);
      check_eq("arst_mode", d, 32'd0);
      bus_read(R_DISP, d);
      check_eq("arst_disp", d, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      bus_read(R_STATUS, d);
      check_eq("post_rst_status", d, 32'd0);
      set_exp_hex(32'd0);
      check_scan();

      // Reset landing on the confirm edge
      @(posedge clk);
      #1;
      confirm_btn = 1'b1;
      repeat (DEBOUNCE + 2) @(posedge clk);
      #1;
      bus_read(R_STATUS, d);
      check_eq("pending_pre_edge", {31'd0, d[0]}, 32'd0);
      rst_n = 1'b0;
      #1;
      bus_read(R_SW, d);
      check_eq("edge_rst_sw", d, 32'd0);
      confirm_btn = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (DEBOUNCE + 10) @(posedge clk);
      #1;
      bus_read(R_STATUS, d);
      check_eq("edge_rst_pending", {31'd0, d[0]}, 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
